// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM state encoding and the alignment rule for RV32 loads and stores.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Halves need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: request from the MEM stage, response from the memory.
interface data_mem_responder_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        ACCESS_FAULT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
        input  READ_DATA, BUSYWAIT, ACCESS_FAULT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
        output READ_DATA, BUSYWAIT, ACCESS_FAULT
    );
endinterface

// File: rtl/data_mem_responder_load_store_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// load byte/half extraction with extension, and fault detection.
module load_store_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        fault
);
    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Unsigned variants exist only for loads.
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;
            default:          illegal = 1'b1;
        endcase
    end

    assign fault = illegal | is_misaligned(funct3, addr_lo);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign byte_en[gi] = is_store && !fault &&
                             ((funct3 == F3_W) ||
                              (funct3 == F3_H && addr_lo[1] == LANE[1]) ||
                              (funct3 == F3_B && addr_lo == LANE));
        assign store_word[8*gi +: 8] = (funct3 == F3_B) ? store_data[7:0] :
                                       (funct3 == F3_H) ? store_data[8*(gi%2) +: 8] :
                                                          store_data[8*gi +: 8];
    end

    assign ld_byte = mem_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    load_data = mem_word;
            F3_BU:   load_data = {24'h0, ld_byte};
            F3_HU:   load_data = {16'h0, ld_half};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a fixed-latency BUSYWAIT handshake,
// committing each access at the edge that ends its last busy cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic CLK,
    input  logic RESET,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            commit;
    logic            busy;
    logic [31:0]     read_data_reg;
    logic            fault_reg;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   word_idx;
    logic            req;
    logic [3:0]      byte_en;
    logic [31:0]     store_word;
    logic [31:0]     load_data;
    logic            fault;
    logic            addr_unused;

    // Upper address bits are dropped so out-of-range addresses alias.
    assign word_idx    = bus.MEM_ADDRESS[AW+1:2];
    assign addr_unused = ^bus.MEM_ADDRESS[31:AW+2];
    assign req         = bus.MEM_READ | bus.MEM_WRITE;

    load_store_align u_align (
        .funct3     (bus.MEM_FUNCT3),
        .addr_lo    (bus.MEM_ADDRESS[1:0]),
        .is_store   (bus.MEM_WRITE),
        .store_data (bus.MEM_WRITE_DATA),
        .mem_word   (mem[word_idx]),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .fault      (fault)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    busy = 1'b1;
                    if (LATENCY == 1) begin
                        commit     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        count_next = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count_reg == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            read_data_reg <= '0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            fault_reg <= commit & fault;
            // A simultaneous read+write is a store, so only pure loads update READ_DATA.
            if (commit && bus.MEM_READ && !bus.MEM_WRITE)
                read_data_reg <= fault ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
        end
    end

    // Held low during reset so an aborted access releases the CPU at once.
    assign bus.BUSYWAIT     = busy & ~RESET;
    assign bus.READ_DATA    = read_data_reg;
    assign bus.ACCESS_FAULT = fault_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table on a LATENCY=4 instance, plus
// hand sequences for reset abort and back-to-back LATENCY=1 accesses.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   txn = 0;
    exp_t sb_q[$];
    vec_t vecs[25];

    data_mem_responder_if if4();
    data_mem_responder_if if1();

    data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_dut4 (.CLK(CLK), .RESET(RESET), .bus(if4));
    data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (which == 1) begin
            if1.MEM_READ = rd; if1.MEM_WRITE = wr; if1.MEM_FUNCT3 = f3;
            if1.MEM_ADDRESS = a; if1.MEM_WRITE_DATA = wd;
        end else begin
            if4.MEM_READ = rd; if4.MEM_WRITE = wr; if4.MEM_FUNCT3 = f3;
            if4.MEM_ADDRESS = a; if4.MEM_WRITE_DATA = wd;
        end
    endtask

    function automatic logic get_bw(input int which);
        return (which == 1) ? if1.BUSYWAIT : if4.BUSYWAIT;
    endfunction

    function automatic logic [31:0] get_rd(input int which);
        return (which == 1) ? if1.READ_DATA : if4.READ_DATA;
    endfunction

    function automatic logic get_af(input int which);
        return (which == 1) ? if1.ACCESS_FAULT : if4.ACCESS_FAULT;
    endfunction

    // Entered at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
    task automatic do_access(input int which, input vec_t v);
        exp_t e;
        int   busy_cnt;
        logic done;
        drive(which, v.rd, v.wr, v.f3, v.addr, v.wdata);
        sb_q.push_back('{data: v.exp_data, fault: v.exp_fault});
        #1;
        busy_cnt = 0;
        done = 1'b0;
        for (int budget = 0; budget < 20 && !done; budget++) begin
            if (get_bw(which)) begin
                busy_cnt++;
                @(posedge CLK); #1;
            end else begin
                done = 1'b1;
            end
        end
        e = sb_q.pop_front();
        if (!done) begin
            tests++; fails++;
            $display("[TB] FAIL timeout txn %0d: BUSYWAIT still high after 20 cycles", txn);
        end else begin
            check("read_data", get_rd(which), e.data);
            check("access_fault", {31'b0, get_af(which)}, {31'b0, e.fault});
            check("busy_cycles", busy_cnt, (which == 1) ? 1 : 4);
        end
        $display("[TB] txn %0d lat=%0d rd=%0b wr=%0b f3=%b addr=%h wd=%h -> data=%h fault=%0b busy=%0d",
                 txn, (which == 1) ? 1 : 4, v.rd, v.wr, v.f3, v.addr, v.wdata,
                 get_rd(which), get_af(which), busy_cnt);
        txn++;
        drive(which, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [2:0] f3_bad;
        f3_bad = 3'b011;
        //             rd    wr    f3      addr        wdata         exp_data      fault
        vecs[0]  = '{1'b0, 1'b1, F3_W,  32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, F3_B,  32'h21,  32'h00000080, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, F3_B,  32'h21,  32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, F3_BU, 32'h21,  32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, F3_W,  32'h20,  32'h0,        32'h00008000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, F3_H,  32'h32,  32'h0000ABCD, 32'h00008000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, F3_H,  32'h32,  32'h0,        32'hFFFFABCD, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, F3_HU, 32'h32,  32'h0,        32'h0000ABCD, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, F3_W,  32'h41,  32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, F3_W,  32'h40,  32'h0,        32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, f3_bad, 32'h10, 32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[14] = '{1'b0, 1'b1, F3_H,  32'h11,  32'h00001234, 32'hDEADBEEF, 1'b1};
        vecs[15] = '{1'b0, 1'b1, F3_BU, 32'h10,  32'h00000011, 32'hDEADBEEF, 1'b1};
        vecs[16] = '{1'b1, 1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[17] = '{1'b1, 1'b1, F3_W,  32'h50,  32'h55AA55AA, 32'hDEADBEEF, 1'b0};
        vecs[18] = '{1'b1, 1'b0, F3_W,  32'h50,  32'h0,        32'h55AA55AA, 1'b0};
        vecs[19] = '{1'b1, 1'b0, F3_W,  32'h410, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[20] = '{1'b0, 1'b1, F3_B,  32'h13,  32'h0000007F, 32'hDEADBEEF, 1'b0};
        vecs[21] = '{1'b1, 1'b0, F3_W,  32'h10,  32'h0,        32'h7FADBEEF, 1'b0};
        vecs[22] = '{1'b1, 1'b0, F3_B,  32'h12,  32'h0,        32'hFFFFFFAD, 1'b0};
        vecs[23] = '{1'b1, 1'b0, F3_H,  32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[24] = '{1'b1, 1'b0, F3_HU, 32'h12,  32'h0,        32'h00007FAD, 1'b0};

        drive(4, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busywait", {31'b0, if4.BUSYWAIT}, 32'h0);
        check("reset_read_data", if4.READ_DATA, 32'h0);
        check("reset_access_fault", {31'b0, if4.ACCESS_FAULT}, 32'h0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 25; i++)
            do_access(4, vecs[i]);

        // LATENCY=1: set two words, then hold a load across DONE to see 1,0,1,0.
        do_access(1, '{1'b0, 1'b1, F3_W, 32'h0, 32'h12345678, 32'h0, 1'b0});
        do_access(1, '{1'b0, 1'b1, F3_W, 32'h4, 32'h9ABCDEF0, 32'h0, 1'b0});
        drive(1, 1'b1, 1'b0, F3_W, 32'h4, 32'h0);
        #1;
        check("b2b_bw0", {31'b0, if1.BUSYWAIT}, 32'h1);
        @(posedge CLK); #1;
        check("b2b_bw1", {31'b0, if1.BUSYWAIT}, 32'h0);
        check("b2b_data1", if1.READ_DATA, 32'h9ABCDEF0);
        if1.MEM_ADDRESS = 32'h400;
        @(posedge CLK); #1;
        check("b2b_bw2", {31'b0, if1.BUSYWAIT}, 32'h1);
        @(posedge CLK); #1;
        check("b2b_bw3", {31'b0, if1.BUSYWAIT}, 32'h0);
        check("b2b_data_alias", if1.READ_DATA, 32'h12345678);
        check("b2b_fault", {31'b0, if1.ACCESS_FAULT}, 32'h0);
        $display("[TB] txn %0d lat=1 back-to-back LW 0x4 then 0x400 -> data=%h", txn, if1.READ_DATA);
        txn++;
        drive(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge CLK); #1;

        // Abort a store mid-flight with an asynchronous reset pulse.
        drive(4, 1'b0, 1'b1, F3_W, 32'h60, 32'hCAFEF00D);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("abort_busy_before", {31'b0, if4.BUSYWAIT}, 32'h1);
        #2 RESET = 1'b1;
        #1;
        check("abort_busy_dropped", {31'b0, if4.BUSYWAIT}, 32'h0);
        check("abort_read_data", if4.READ_DATA, 32'h0);
        $display("[TB] txn %0d lat=4 SW 0x60 aborted by reset in BUSY", txn);
        txn++;
        drive(4, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        do_access(4, '{1'b0, 1'b1, F3_W, 32'h64, 32'h0BADF00D, 32'h0, 1'b0});
        do_access(4, '{1'b1, 1'b0, F3_W, 32'h64, 32'h0, 32'h0BADF00D, 1'b0});
        do_access(4, '{1'b1, 1'b0, F3_W, 32'h60, 32'h0, 32'h00000000, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
